// File: rtl/up_axi4l_master_pkg.sv
// Shared types and helpers for the up_axi4l_master register-access bridge.
// Holds the FSM state encoding, AXI response codes and address/response helpers.
// No logic of its own; imported by the master.
package up_axi4l_master_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR,
    ST_WR_RESP,
    ST_RD_ADDR,
    ST_RD_DATA
  } up_axi4l_state_t;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  // Word address to byte address; the 32-bit sum wraps naturally.
  function automatic logic [31:0] up_byte_addr(input logic [31:0] base, input logic [31:0] word);
    return base + (word << 2);
  endfunction

  // SLVERR and DECERR both flag an error; OKAY/EXOKAY do not.
  function automatic logic resp_is_err(input logic [1:0] resp);
    return (resp == AXI_RESP_SLVERR) || (resp == AXI_RESP_DECERR);
  endfunction

endpackage

// File: rtl/up_axi4l_master.sv
// AXI4-Lite master bridging single-word up_wr/up_rd requests onto AW/W/B and AR/R.
// Latency: VALIDs one cycle after request; ack one cycle after the B or R handshake.
// Backpressure: one transaction in flight plus one queued read; requests while busy are dropped.
//
// Ports: aclk/aresetn (sync, active-low); up_wr_* / up_rd_* request side with one-cycle
// ack/err pulses; busy; m_axi_* AXI4-Lite master (32-bit addr/data, 4-bit strb).
// Optional watchdog: define UP_AXI4L_MASTER_TIMEOUT_EN to abort after C_TIMEOUT cycles.
module up_axi4l_master
  import up_axi4l_master_pkg::*;
#(
  parameter int          C_ADDR_WIDTH = 10,
  parameter int          C_DATA_WIDTH = 32,
  parameter logic [31:0] C_BASE_ADDR  = 32'h0000_0000,
  parameter int          C_TIMEOUT    = 1024
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic [C_ADDR_WIDTH-1:0] up_wr_addr,
  input  logic                    up_wr_req,
  input  logic [3:0]              up_wr_be,
  input  logic [C_DATA_WIDTH-1:0] up_wr_din,
  output logic                    up_wr_ack,
  output logic                    up_wr_err,
  input  logic [C_ADDR_WIDTH-1:0] up_rd_addr,
  input  logic                    up_rd_req,
  output logic [C_DATA_WIDTH-1:0] up_rd_dout,
  output logic                    up_rd_ack,
  output logic                    up_rd_err,
  output logic                    busy,
  output logic [31:0]             m_axi_awaddr,
  output logic [2:0]              m_axi_awprot,
  output logic                    m_axi_awvalid,
  input  logic                    m_axi_awready,
  output logic [31:0]             m_axi_wdata,
  output logic [3:0]              m_axi_wstrb,
  output logic                    m_axi_wvalid,
  input  logic                    m_axi_wready,
  input  logic [1:0]              m_axi_bresp,
  input  logic                    m_axi_bvalid,
  output logic                    m_axi_bready,
  output logic [31:0]             m_axi_araddr,
  output logic [2:0]              m_axi_arprot,
  output logic                    m_axi_arvalid,
  input  logic                    m_axi_arready,
  input  logic [31:0]             m_axi_rdata,
  input  logic [1:0]              m_axi_rresp,
  input  logic                    m_axi_rvalid,
  output logic                    m_axi_rready
);

  if (C_DATA_WIDTH != 32 || C_TIMEOUT < 1) begin : g_param_check
    $error("up_axi4l_master: C_DATA_WIDTH must be 32 and C_TIMEOUT >= 1");
  end

  up_axi4l_state_t state;
  logic            rd_pend;
`ifdef UP_AXI4L_MASTER_TIMEOUT_EN
  logic [31:0]     tmo_cnt;
`endif

  assign m_axi_awprot = 3'b000;
  assign m_axi_arprot = 3'b000;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state         <= ST_IDLE;
      rd_pend       <= 1'b0;
      busy          <= 1'b0;
      up_wr_ack     <= 1'b0;
      up_wr_err     <= 1'b0;
      up_rd_ack     <= 1'b0;
      up_rd_err     <= 1'b0;
      up_rd_dout    <= '0;
      m_axi_awaddr  <= '0;
      m_axi_awvalid <= 1'b0;
      m_axi_wdata   <= '0;
      m_axi_wstrb   <= '0;
      m_axi_wvalid  <= 1'b0;
      m_axi_bready  <= 1'b0;
      m_axi_araddr  <= '0;
      m_axi_arvalid <= 1'b0;
      m_axi_rready  <= 1'b0;
`ifdef UP_AXI4L_MASTER_TIMEOUT_EN
      tmo_cnt       <= '0;
`endif
    end else begin
      up_wr_ack <= 1'b0;
      up_wr_err <= 1'b0;
      up_rd_ack <= 1'b0;
      up_rd_err <= 1'b0;
`ifdef UP_AXI4L_MASTER_TIMEOUT_EN
      tmo_cnt <= (state == ST_IDLE) ? '0 : tmo_cnt + 32'd1;
`endif

      case (state)
        ST_IDLE: begin
          if (up_wr_req) begin
            m_axi_awaddr  <= up_byte_addr(C_BASE_ADDR, 32'(up_wr_addr));
            m_axi_wdata   <= up_wr_din;
            m_axi_wstrb   <= up_wr_be;
            m_axi_awvalid <= 1'b1;
            m_axi_wvalid  <= 1'b1;
            busy          <= 1'b1;
            state         <= ST_WR;
            // A simultaneous read waits behind the write.
            if (up_rd_req) begin
              rd_pend      <= 1'b1;
              m_axi_araddr <= up_byte_addr(C_BASE_ADDR, 32'(up_rd_addr));
            end
          end else if (up_rd_req) begin
            m_axi_araddr  <= up_byte_addr(C_BASE_ADDR, 32'(up_rd_addr));
            m_axi_arvalid <= 1'b1;
            busy          <= 1'b1;
            state         <= ST_RD_ADDR;
          end
        end

        ST_WR: begin
          if (m_axi_awvalid && m_axi_awready) m_axi_awvalid <= 1'b0;
          if (m_axi_wvalid && m_axi_wready)   m_axi_wvalid  <= 1'b0;
          // Each channel is done if already dropped or handshaking now.
          if ((!m_axi_awvalid || m_axi_awready) && (!m_axi_wvalid || m_axi_wready)) begin
            m_axi_bready <= 1'b1;
            state        <= ST_WR_RESP;
          end
        end

        ST_WR_RESP: begin
          if (m_axi_bvalid) begin
            m_axi_bready <= 1'b0;
            up_wr_ack    <= 1'b1;
            up_wr_err    <= resp_is_err(m_axi_bresp);
            if (rd_pend) begin
              // ARVALID is raised from ST_RD_ADDR, one cycle after this ack.
              rd_pend <= 1'b0;
              state   <= ST_RD_ADDR;
`ifdef UP_AXI4L_MASTER_TIMEOUT_EN
              tmo_cnt <= '0;
`endif
            end else begin
              busy  <= 1'b0;
              state <= ST_IDLE;
            end
          end
        end

        ST_RD_ADDR: begin
          if (!m_axi_arvalid) begin
            m_axi_arvalid <= 1'b1;
          end else if (m_axi_arready) begin
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b1;
            state         <= ST_RD_DATA;
          end
        end

        ST_RD_DATA: begin
          if (m_axi_rvalid) begin
            m_axi_rready <= 1'b0;
            up_rd_dout   <= m_axi_rdata;
            up_rd_ack    <= 1'b1;
            up_rd_err    <= resp_is_err(m_axi_rresp);
            busy         <= 1'b0;
            state        <= ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase

`ifdef UP_AXI4L_MASTER_TIMEOUT_EN
      // Watchdog abort, unless the transaction is completing this very cycle.
      if (state != ST_IDLE && tmo_cnt == 32'(C_TIMEOUT - 1) &&
          !(state == ST_WR_RESP && m_axi_bvalid) &&
          !(state == ST_RD_DATA && m_axi_rvalid)) begin
        m_axi_awvalid <= 1'b0;
        m_axi_wvalid  <= 1'b0;
        m_axi_bready  <= 1'b0;
        m_axi_arvalid <= 1'b0;
        m_axi_rready  <= 1'b0;
        if (state == ST_WR || state == ST_WR_RESP) begin
          up_wr_ack <= 1'b1;
          up_wr_err <= 1'b1;
          if (rd_pend) begin
            rd_pend <= 1'b0;
            state   <= ST_RD_ADDR;
            tmo_cnt <= '0;
          end else begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
        end else begin
          up_rd_ack <= 1'b1;
          up_rd_err <= 1'b1;
          busy      <= 1'b0;
          state     <= ST_IDLE;
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_up_axi4l_master.sv
`timescale 1ns/1ps
module tb_up_axi4l_master;
  import up_axi4l_master_pkg::*;

  localparam int          AW   = 10;
  localparam logic [31:0] BASE = 32'h4000_0000;
  localparam int          TMO  = 16;

  logic clk = 1'b0;
  logic aresetn;
  always #5 clk = ~clk;

  logic [AW-1:0] up_wr_addr, up_rd_addr;
  logic          up_wr_req, up_rd_req, up_wr_ack, up_wr_err, up_rd_ack, up_rd_err, busy;
  logic [3:0]    up_wr_be;
  logic [31:0]   up_wr_din, up_rd_dout;
  logic [31:0]   awaddr, wdata, araddr, rdata;
  logic [2:0]    awprot, arprot;
  logic [3:0]    wstrb;
  logic [1:0]    bresp, rresp;
  logic          awvalid, awready, wvalid, wready, bvalid, bready;
  logic          arvalid, arready, rvalid, rready;

  up_axi4l_master #(
    .C_ADDR_WIDTH(AW), .C_DATA_WIDTH(32), .C_BASE_ADDR(BASE), .C_TIMEOUT(TMO)
  ) dut (
    .aclk(clk), .aresetn(aresetn),
    .up_wr_addr(up_wr_addr), .up_wr_req(up_wr_req), .up_wr_be(up_wr_be), .up_wr_din(up_wr_din),
    .up_wr_ack(up_wr_ack), .up_wr_err(up_wr_err),
    .up_rd_addr(up_rd_addr), .up_rd_req(up_rd_req), .up_rd_dout(up_rd_dout),
    .up_rd_ack(up_rd_ack), .up_rd_err(up_rd_err), .busy(busy),
    .m_axi_awaddr(awaddr), .m_axi_awprot(awprot), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
    .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wvalid(wvalid), .m_axi_wready(wready),
    .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
    .m_axi_araddr(araddr), .m_axi_arprot(arprot), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
    .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rvalid(rvalid), .m_axi_rready(rready)
  );

  // ---------------- slave model ----------------
  int          aw_dly, w_dly, ar_dly;
  int          aw_wait, w_wait, ar_wait;
  bit          b_hold, r_force;
  logic [31:0] r_force_dat;
  logic [1:0]  r_resp_cfg, b_resp_cfg;
  logic        got_aw, got_w;
  logic [31:0] s_awaddr, s_wdata, a_v, d_v, old_v;
  logic [3:0]  s_wstrb, st_v;
  logic [31:0] last_awaddr, last_wdata, last_araddr;
  logic [3:0]  last_wstrb;
  logic [31:0] mem [logic [31:0]];

  assign awready = awvalid && (aw_wait >= aw_dly);
  assign wready  = wvalid  && (w_wait  >= w_dly);
  assign arready = arvalid && (ar_wait >= ar_dly);

  always @(posedge clk) begin
    if (!aresetn) begin
      aw_wait <= 0; w_wait <= 0; ar_wait <= 0;
      got_aw <= 1'b0; got_w <= 1'b0; bvalid <= 1'b0; rvalid <= 1'b0;
      bresp <= 2'b00; rresp <= 2'b00; rdata <= '0;
    end else begin
      aw_wait <= (awvalid && !awready) ? aw_wait + 1 : 0;
      w_wait  <= (wvalid  && !wready)  ? w_wait  + 1 : 0;
      ar_wait <= (arvalid && !arready) ? ar_wait + 1 : 0;
      if (awvalid && awready) begin got_aw <= 1'b1; s_awaddr <= awaddr; last_awaddr <= awaddr; end
      if (wvalid && wready) begin
        got_w <= 1'b1; s_wdata <= wdata; s_wstrb <= wstrb; last_wdata <= wdata; last_wstrb <= wstrb;
      end
      if (bvalid && bready) begin
        bvalid <= 1'b0;
      end else if (!bvalid && !b_hold && (got_aw || (awvalid && awready)) && (got_w || (wvalid && wready))) begin
        a_v   = (awvalid && awready) ? awaddr : s_awaddr;
        d_v   = (wvalid && wready) ? wdata : s_wdata;
        st_v  = (wvalid && wready) ? wstrb : s_wstrb;
        old_v = mem.exists(a_v) ? mem[a_v] : 32'h0;
        for (int i = 0; i < 4; i++) if (st_v[i]) old_v[i*8 +: 8] = d_v[i*8 +: 8];
        mem[a_v] = old_v;
        bvalid <= 1'b1; bresp <= b_resp_cfg; got_aw <= 1'b0; got_w <= 1'b0;
      end
      if (rvalid && rready) rvalid <= 1'b0;
      if (arvalid && arready) begin
        rvalid      <= 1'b1;
        last_araddr <= araddr;
        rresp       <= r_resp_cfg;
        rdata       <= r_force ? r_force_dat : (mem.exists(araddr) ? mem[araddr] : 32'h0);
      end
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    bit          is_rd;
    bit          err;
    logic [31:0] dat;
    int          lat;
    int          req_cyc;
  } exp_t;
  exp_t exp_q[$];

  int n_vec = 0, n_err = 0, cyc = 0, last_req_cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    if (up_wr_ack || up_rd_ack) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_ack", 32'(1), 32'(0));
      end else begin
        e = exp_q.pop_front();
        chk("ack_kind", 32'(up_rd_ack), 32'(e.is_rd));
        chk("ack_err", 32'(e.is_rd ? up_rd_err : up_wr_err), 32'(e.err));
        if (e.is_rd) chk("rd_dout", up_rd_dout, e.dat);
        if (e.lat > 0) chk("ack_latency", 32'(cyc - e.req_cyc), 32'(e.lat));
        chk("busy_at_ack", 32'(busy), 32'(exp_q.size() != 0));
      end
    end
  end

  task automatic push_exp(input bit is_rd, input bit err, input logic [31:0] dat, input int lat);
    exp_t e;
    e.is_rd = is_rd; e.err = err; e.dat = dat; e.lat = lat; e.req_cyc = last_req_cyc;
    exp_q.push_back(e);
  endtask

  task automatic drive_req(input bit wr, input bit rd, input logic [AW-1:0] waddr,
                           input logic [31:0] wdat, input logic [3:0] be, input logic [AW-1:0] raddr);
    @(negedge clk);
    up_wr_req = wr; up_wr_addr = waddr; up_wr_din = wdat; up_wr_be = be;
    up_rd_req = rd; up_rd_addr = raddr;
    last_req_cyc = cyc;
    @(negedge clk);
    up_wr_req = 1'b0; up_rd_req = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    chk("drain", {30'b0, busy, exp_q.size() != 0}, 32'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, want completion");
    $fatal(1, "global timeout");
  end

  initial begin
    int aw_hi, w_hi;
    aresetn = 1'b0;
    up_wr_req = 0; up_rd_req = 0; up_wr_addr = '0; up_rd_addr = '0; up_wr_be = '0; up_wr_din = '0;
    aw_dly = 0; w_dly = 0; ar_dly = 0; b_hold = 0; r_force = 0; r_force_dat = '0;
    r_resp_cfg = AXI_RESP_OKAY; b_resp_cfg = AXI_RESP_OKAY;
    repeat (3) @(negedge clk);
    chk("rst_awvalid", 32'(awvalid), 32'(0));
    chk("rst_wvalid", 32'(wvalid), 32'(0));
    chk("rst_arvalid", 32'(arvalid), 32'(0));
    chk("rst_bready", 32'(bready), 32'(0));
    chk("rst_rready", 32'(rready), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_acks", {30'b0, up_wr_ack, up_rd_ack}, 32'(0));
    chk("rst_dout", up_rd_dout, 32'h0);
    aresetn = 1'b1;

    // Basic write, slave always ready.
    drive_req(1, 0, 10'h004, 32'hDEAD_BEEF, 4'hF, '0);
    push_exp(0, 0, '0, 3);
    chk("busy_rise", 32'(busy), 32'(1));
    chk("awvalid_n1", 32'(awvalid), 32'(1));
    wait_done(20);
    chk("awaddr", last_awaddr, 32'h4000_0010);
    chk("wstrb", 32'(last_wstrb), 32'hF);
    chk("wdata", last_wdata, 32'hDEAD_BEEF);
    chk("awprot", 32'(awprot), 32'(0));

    // Write with AWREADY 3 cycles late, WREADY 1 cycle late.
    aw_dly = 3; w_dly = 1;
    drive_req(1, 0, 10'h008, 32'h0BAD_F00D, 4'h3, '0);
    push_exp(0, 0, '0, 6);
    aw_hi = 0; w_hi = 0;
    for (int i = 0; i < 9; i++) begin
      if (awvalid) aw_hi++;
      if (wvalid) w_hi++;
      @(negedge clk);
    end
    chk("aw_hi_cycles", 32'(aw_hi), 32'(4));
    chk("w_hi_cycles", 32'(w_hi), 32'(2));
    chk("awaddr_dly", last_awaddr, 32'h4000_0020);
    chk("wstrb_dly", 32'(last_wstrb), 32'h3);
    wait_done(20);
    aw_dly = 0; w_dly = 0;

    // Simultaneous write and read of the same word.
    drive_req(1, 1, 10'h010, 32'hCAFE_0123, 4'hF, 10'h010);
    push_exp(0, 0, '0, 3);
    push_exp(1, 0, 32'hCAFE_0123, 6);
    wait_done(30);
    chk("araddr", last_araddr, 32'h4000_0040);

    // Read with SLVERR; write with DECERR.
    r_force = 1; r_force_dat = 32'h1234_5678; r_resp_cfg = AXI_RESP_SLVERR;
    drive_req(0, 1, '0, '0, '0, 10'h020);
    push_exp(1, 1, 32'h1234_5678, 3);
    wait_done(20);
    r_force = 0; r_resp_cfg = AXI_RESP_OKAY;
    b_resp_cfg = AXI_RESP_DECERR;
    drive_req(1, 0, 10'h024, 32'h1111_2222, 4'hF, '0);
    push_exp(0, 1, '0, 3);
    wait_done(20);
    b_resp_cfg = AXI_RESP_OKAY;

    // Reset while waiting in WR_RESP: abandoned, never acked.
    b_hold = 1;
    drive_req(1, 0, 10'h030, 32'h5555_AAAA, 4'hF, '0);
    for (int i = 0; i < 10 && !bready; i++) @(negedge clk);
    chk("wr_resp_reached", 32'(bready), 32'(1));
    aresetn = 1'b0;
    @(negedge clk);
    chk("mid_rst_awvalid", 32'(awvalid), 32'(0));
    chk("mid_rst_wvalid", 32'(wvalid), 32'(0));
    chk("mid_rst_bready", 32'(bready), 32'(0));
    chk("mid_rst_busy", 32'(busy), 32'(0));
    chk("mid_rst_dout", up_rd_dout, 32'h0);
    aresetn = 1'b1; b_hold = 0;
    repeat (5) @(negedge clk);
    drive_req(0, 1, '0, '0, '0, 10'h010);
    push_exp(1, 0, 32'hCAFE_0123, 3);
    wait_done(20);

    // Write issued while busy with a read is dropped.
    drive_req(0, 1, '0, '0, '0, 10'h010);
    push_exp(1, 0, 32'hCAFE_0123, 3);
    drive_req(1, 0, 10'h040, 32'h9999_9999, 4'hF, '0);
    wait_done(20);
    chk("dropped_wr_mem", 32'(mem.exists(32'h4000_0100)), 32'(0));
    chk("dropped_wr_aw", last_awaddr, 32'h4000_00C0);

    // Read data is held across a later write.
    drive_req(1, 0, 10'h050, 32'h7777_0000, 4'hF, '0);
    push_exp(0, 0, '0, 3);
    wait_done(20);
    chk("dout_hold", up_rd_dout, 32'hCAFE_0123);

`ifdef UP_AXI4L_MASTER_TIMEOUT_EN
    // Slave never accepts AR: watchdog aborts with err.
    ar_dly = 1000;
    drive_req(0, 1, '0, '0, '0, 10'h010);
    push_exp(1, 1, 32'hCAFE_0123, TMO + 1);
    wait_done(40);
    chk("tmo_arvalid", 32'(arvalid), 32'(0));
    ar_dly = 0;
`endif

    chk("queue_empty", 32'(exp_q.size()), 32'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
